// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each granted transaction takes three cycles: IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              busy,
   output logic              grant_id
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_q;
   logic              last_q;
   logic              grant_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              mem_write_q;
   logic              ack0_q;
   logic              ack1_q;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;
   logic              busy_q;

   logic              gnt_d;
   logic              we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;

   // Under contention the requester that did not win last time is chosen.
   always_comb begin
      gnt_d   = req1 & (~req0 | ~last_q);
      we_d    = gnt_d ? we1    : we0;
      addr_d  = gnt_d ? addr1  : addr0;
      wdata_d = gnt_d ? wdata1 : wdata0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         grant_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mem_write_q <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  state_q     <= ACCESS;
                  grant_q     <= gnt_d;
                  last_q      <= gnt_d;
                  we_q        <= we_d;
                  addr_q      <= addr_d;
                  wdata_q     <= wdata_d;
                  mem_write_q <= we_d;
                  busy_q      <= 1'b1;
               end
            end
            ACCESS: begin
               state_q     <= RESP;
               mem_write_q <= 1'b0;
               ack0_q      <= ~grant_q;
               ack1_q      <= grant_q;
               if (!we_q) begin
                  if (grant_q) rdata1_q <= mem_read_data;
                  else         rdata0_q <= mem_read_data;
               end
            end
            RESP: begin
               // Requests still high here are only seen on the next IDLE edge.
               state_q <= IDLE;
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               mem_write_q <= 1'b0;
               ack0_q      <= 1'b0;
               ack1_q      <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign ack0           = ack0_q;
   assign ack1           = ack1_q;
   assign rdata0         = rdata0_q;
   assign rdata1         = rdata1_q;
   assign mem_write      = mem_write_q;
   assign mem_address    = addr_q;
   assign mem_write_data = wdata_q;
   assign busy           = busy_q;
   assign grant_id       = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level model with its own reference memory.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
   logic        ack0, ack1, mem_write, busy, grant_id;
   logic [31:0] rdata0, rdata1, mem_address, mem_write_data, mem_read_data;

   logic [31:0] phys_mem [16] = '{default: 32'h0};

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_write(mem_write), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   assign mem_read_data = phys_mem[mem_address[5:2]];
   always @(posedge clk) if (mem_write) phys_mem[mem_address[5:2]] <= mem_write_data;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Transaction-level model: a grant at edge S owns edges S..S+2;
   // memory is touched at S+1 and the ack is visible between S+1 and S+2.
   int          e_cnt, m_start, m_done;
   bit          m_busy, m_last, m_g, m_we;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] exp_rd [2];
   logic [31:0] ref_mem [16];

   task automatic model_reset();
      e_cnt = 0; m_start = -10; m_busy = 0; m_last = 1; m_g = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; exp_rd[0] = 0; exp_rd[1] = 0;
   endtask

   task automatic model_edge();
      if (reset) return;
      e_cnt++;
      if (m_busy) begin
         if (e_cnt == m_start + 1) begin
            if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
            else      exp_rd[m_g] = ref_mem[m_addr[5:2]];
            m_done++;
         end else if (e_cnt == m_start + 2) begin
            m_busy = 0;
         end
      end else if (req0 || req1) begin
         m_g     = (req0 && req1) ? !m_last : req1;
         m_last  = m_g;
         m_start = e_cnt;
         m_busy  = 1;
         m_we    = m_g ? we1 : we0;
         m_addr  = m_g ? addr1 : addr0;
         m_wdata = m_g ? wdata1 : wdata0;
      end
   endtask

   task automatic check_outputs();
      bit exp_ack;
      exp_ack = m_busy && (e_cnt == m_start + 1);
      check("busy", busy, m_busy);
      check("mem_write", mem_write, m_busy && (e_cnt == m_start) && m_we);
      check("ack0", ack0, exp_ack && !m_g);
      check("ack1", ack1, exp_ack && m_g);
      check("ack_both", ack0 & ack1, 0);
      check("mem_address", mem_address, m_addr);
      check("mem_write_data", mem_write_data, m_wdata);
      check("rdata0", rdata0, exp_rd[0]);
      check("rdata1", rdata1, exp_rd[1]);
      if (m_busy) check("grant_id", grant_id, m_g);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      reset = 1;
      req0 = 0; req1 = 0;
      @(negedge clk);
      model_reset();
      reset = 0;
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < 16; i++) ref_mem[i] = 0;
      m_done = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_ack", {ack1, ack0}, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_addr", mem_address, 0);
      check("rst_wdata", mem_write_data, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      check("rst_grant", grant_id, 0);
      reset = 0;

      // Single write then read-back by the other requester
      req0 = 1; we0 = 1; addr0 = 8; wdata0 = 32'hDEADBEEF;
      step();
      check("wr_mem_write", mem_write, 1);
      check("wr_mem_address", mem_address, 8);
      step();
      check("wr_ack0", ack0, 1);
      check("wr_rdata0", rdata0, 0);
      check("wr_mem_write_off", mem_write, 0);
      req0 = 0;
      step();
      check("wr_ack0_off", ack0, 0);
      req1 = 1; we1 = 0; addr1 = 8;
      step();
      step();
      check("rd_ack1", ack1, 1);
      check("rd_rdata1", rdata1, 32'hDEADBEEF);
      check("rd_rdata0", rdata0, 0);
      req1 = 0;
      step();

      // Held contention: grants alternate 0,1,0,1 with acks 3 cycles apart
      do_reset();
      req0 = 1; we0 = 0; addr0 = 4;
      req1 = 1; we1 = 0; addr1 = 12;
      for (int c = 1; c <= 12; c++) begin
         step();
         check("cont_ack0", ack0, (c % 6) == 2);
         check("cont_ack1", ack1, (c % 6) == 5);
         if (c % 3 == 1) check("cont_grant", grant_id, ((c - 1) / 3) % 2);
         if (c % 3 == 0) check("cont_gap", busy, 0);
      end
      req0 = 0; req1 = 0;
      repeat (3) step();

      // Request dropped right after being sampled still completes, once
      req1 = 1; we1 = 0; addr1 = 12;
      step();
      req1 = 0;
      step();
      check("drop_ack1", ack1, 1);
      step();
      step();
      check("drop_idle", busy, 0);
      step();
      check("drop_no_ack", ack1, 0);

      // Reset during the ACCESS cycle of a write
      req0 = 1; we0 = 1; addr0 = 20; wdata0 = 32'h12345678;
      step();
      check("mid_mem_write_pre", mem_write, 1);
      #2 reset = 1;
      #1;
      check("mid_mem_write", mem_write, 0);
      check("mid_busy", busy, 0);
      check("mid_ack", {ack1, ack0}, 0);
      check("mid_rdata0", rdata0, 0);
      check("mid_rdata1", rdata1, 0);
      check("mid_addr", mem_address, 0);
      model_reset();
      req0 = 0;
      @(negedge clk);
      reset = 0;
      repeat (3) step();
      check("mid_no_ack", ack0, 0);

      // Random traffic: requesters hold until ack, may re-request at once
      m_done = 0;
      cyc = 0;
      while (m_done < 200 && cyc < 5000) begin
         if (ack0) req0 = 0;
         if (ack1) req1 = 0;
         if (!req0 && $urandom_range(0, 1) == 1) begin
            req0 = 1; we0 = $urandom_range(0, 1);
            addr0 = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; wdata0 = $urandom;
         end
         if (!req1 && $urandom_range(0, 1) == 1) begin
            req1 = 1; we1 = $urandom_range(0, 1);
            addr1 = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; wdata1 = $urandom;
         end
         step();
         cyc++;
      end
      check("rand_timeout", m_done >= 200, 1);
      req0 = 0; req1 = 0;
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
